// File: rtl/prm_pkg.sv
// Shared types and sizing for the programmable PRM edge-mask engine.
// Contents: engine sizes, FSM state enum, cube/edge table entry layouts, cube match helper.
// The entry layouts match the cfg_wdata wire format bit for bit.
package prm_pkg;

    localparam int N_IN    = 15;   // occupancy bits per query / literals per cube
    localparam int N_TERMS = 512;  // cube memory depth (power of 2)
    localparam int N_EDGES = 64;   // edges evaluated per query
    localparam int TAW     = $clog2(N_TERMS);
    localparam int EAW     = $clog2(N_EDGES);

    typedef enum logic [1:0] {
        IDLE,
        EDGE,
        SCAN,
        DONE
    } state_t;

    // {care, val}: care bits select which literals the cube tests.
    typedef struct packed {
        logic [N_IN-1:0] care;
        logic [N_IN-1:0] val;
    } cube_t;

    // {count, start}: count is one bit wider than an address so a full-memory
    // run (N_TERMS cubes) is expressible.
    typedef struct packed {
        logic [TAW:0]   count;
        logic [TAW-1:0] start;
    } edge_t;

    // A cube matches when every cared-for literal equals its val bit.
    function automatic logic cube_match(input logic [N_IN-1:0] occ, input cube_t cube);
        return ((occ ^ cube.val) & cube.care) == '0;
    endfunction

endpackage

// File: rtl/prm_cube_mem.sv
// Cube memory: N_TERMS x cube_t register array, one write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// No backpressure; contents are deliberately not reset.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module prm_cube_mem
    import prm_pkg::*;
(
    input  logic           clk_i,
    input  logic           we_i,
    input  logic [TAW-1:0] waddr_i,
    input  cube_t          wdata_i,
    input  logic [TAW-1:0] raddr_i,
    output cube_t          rdata_o
);

    cube_t mem_q [N_TERMS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prm_edge_mask_engine.sv
// Evaluates the sum-of-products blocked function of N_EDGES roadmap edges against one occupancy vector.
// Latency: accept -> out_valid = N_EDGES + total cubes scanned (early exit on first matching cube).
// Backpressure: result held in DONE until out_ready; in_ready low and config writes rejected while busy.
// Ports: CLK/RST; cfg_we/cfg_sel/cfg_addr/cfg_wdata/cfg_err (table load);
//        occ/in_valid/in_ready (query); edge_mask/out_valid/out_ready (result); busy.
module prm_edge_mask_engine
    import prm_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                cfg_we,
    input  logic                cfg_sel,
    input  logic [TAW-1:0]      cfg_addr,
    input  logic [2*N_IN-1:0]   cfg_wdata,
    output logic                cfg_err,
    input  logic [N_IN-1:0]     occ,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N_EDGES-1:0]  edge_mask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    state_t               state_q, state_d;
    logic [N_IN-1:0]      occ_q, occ_d;
    logic [EAW-1:0]       e_q, e_d;
    logic [TAW-1:0]       ptr_q, ptr_d;
    logic [TAW:0]         rem_q, rem_d;
    logic [N_EDGES-1:0]   mask_q, mask_d;
    logic                 cfg_err_q, cfg_err_d;

    edge_t                edge_tbl_q [N_EDGES];
    edge_t                edge_rd;
    cube_t                cube_rd;
    logic [TAW:0]         count_clamped;
    logic                 idle;
    logic                 cfg_ok;
    logic                 last_edge;
    logic                 hit;

    assign idle   = (state_q == IDLE);
    // Writes land on the same edge that may accept a query, so the scan
    // that follows already sees the new table contents.
    assign cfg_ok = cfg_we & idle;

    // Edge table (not reset: tables survive RST).
    always_ff @(posedge CLK) begin
        if (cfg_ok && cfg_sel) begin
            edge_tbl_q[cfg_addr[EAW-1:0]] <= edge_t'(cfg_wdata[$bits(edge_t)-1:0]);
        end
    end

    prm_cube_mem u_cube_mem (
        .clk_i   (CLK),
        .we_i    (cfg_ok & ~cfg_sel),
        .waddr_i (cfg_addr),
        .wdata_i (cube_t'(cfg_wdata)),
        .raddr_i (ptr_q),
        .rdata_o (cube_rd)
    );

    assign edge_rd   = edge_tbl_q[e_q];
    // Clamping keeps a wrapping scan from visiting any cube twice.
    assign count_clamped = (edge_rd.count > (TAW+1)'(N_TERMS)) ? (TAW+1)'(N_TERMS) : edge_rd.count;
    assign hit       = cube_match(occ_q, cube_rd);
    assign last_edge = (e_q == EAW'(N_EDGES - 1));

    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        e_d       = e_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        mask_d    = mask_q;
        cfg_err_d = cfg_we & ~idle;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    occ_d   = occ;
                    e_d     = '0;
                    mask_d  = '0;
                    state_d = EDGE;
                end
            end
            EDGE: begin
                ptr_d = edge_rd.start;
                rem_d = count_clamped;
                if (count_clamped == '0) begin
                    mask_d[e_q] = 1'b0;
                    if (last_edge) begin
                        state_d = DONE;
                    end else begin
                        e_d     = e_q + EAW'(1);
                        state_d = EDGE;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit || rem_q == (TAW+1)'(1)) begin
                    // Either the first match (early exit) or the last cube missed.
                    mask_d[e_q] = hit;
                    if (last_edge) begin
                        state_d = DONE;
                    end else begin
                        e_d     = e_q + EAW'(1);
                        state_d = EDGE;
                    end
                end else begin
                    ptr_d = ptr_q + TAW'(1);   // wraps modulo N_TERMS
                    rem_d = rem_q - (TAW+1)'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            occ_q     <= '0;
            e_q       <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            mask_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            e_q       <= e_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            mask_q    <= mask_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign in_ready  = idle;
    assign busy      = ~idle;
    assign out_valid = (state_q == DONE);
    assign edge_mask = mask_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Directed bench for prm_edge_mask_engine: reset, SOP table vs golden equation, mid-scan reset,
// early exit latency, wrapping scan, back-pressure hold, and config write rejection / same-cycle write.
module tb_prm_edge_mask_engine;
    import prm_pkg::*;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                cfg_we = 1'b0;
    logic                cfg_sel = 1'b0;
    logic [TAW-1:0]      cfg_addr = '0;
    logic [2*N_IN-1:0]   cfg_wdata = '0;
    logic                cfg_err;
    logic [N_IN-1:0]     occ = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N_EDGES-1:0]  edge_mask;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                busy;

    int vectors = 0;
    int miscompares = 0;

    prm_edge_mask_engine dut (
        .CLK       (CLK),
        .RST       (RST),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .occ       (occ),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .edge_mask (edge_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Legacy checker equation, literals A = occ[0] .. O = occ[14].
    function automatic logic golden(input logic [14:0] o);
        return (o[0] & ~o[1] & o[2])                      // A ~B C
             | (o[3] & o[4])                              // D E
             | (~o[5] & o[6] & ~o[7])                     // ~F G ~H
             | (o[8] & o[9] & o[10] & o[11])              // I J K L
             | (~o[12] & ~o[13] & o[14])                  // ~M ~N O
             | (o[0] & o[14] & ~o[4])                     // A O ~E
             | (o[1] & o[2] & o[3] & ~o[6])               // B C D ~G
             | (~o[0] & ~o[2] & o[7] & o[13])             // ~A ~C H N
             | (o[5] & o[9] & ~o[11] & o[12])             // F J ~L M
             | (~o[3] & o[10] & ~o[14] & o[1])            // ~D K ~O B
             | (o[6] & o[7] & o[8])                       // G H I
             | (~o[1] & ~o[4] & ~o[9] & o[13] & o[11]);   // ~B ~E ~J N L
    endfunction

    task automatic write_cfg(input logic sel, input int addr, input logic [2*N_IN-1:0] wdata);
        @(negedge CLK);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = TAW'(addr);
        cfg_wdata = wdata;
        @(negedge CLK);
        cfg_we    = 1'b0;
    endtask

    task automatic write_cube(input int addr, input logic [14:0] care, input logic [14:0] val);
        write_cfg(1'b0, addr, {care, val});
    endtask

    task automatic write_edge(input int e, input int start, input int count);
        logic [2*N_IN-1:0] w;
        w = '0;
        w[TAW-1:0]       = TAW'(start);
        w[2*TAW:TAW]     = (TAW+1)'(count);
        write_cfg(1'b1, e, w);
    endtask

    // Waits (bounded) for out_valid starting at negedge number cnt0 after the accept,
    // returns mask and latency (-1 on timeout), then completes the handshake.
    task automatic finish_query(input int cnt0, output logic [63:0] m, output int lat);
        int cnt;
        cnt = cnt0;
        while (!out_valid && cnt < 3000) begin
            @(negedge CLK);
            cnt++;
        end
        lat = out_valid ? cnt - 1 : -1;
        m   = edge_mask;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic run_query(input logic [14:0] o, output logic [63:0] m, output int lat);
        @(negedge CLK);
        occ      = o;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        finish_query(1, m, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (edge_mask !== 64'h0) begin miscompares++; $display("FAIL reset_edge_mask: got %h want 0", edge_mask); end
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_sop();
        logic [14:0] care [12] = '{15'h0007, 15'h0018, 15'h00E0, 15'h0F00, 15'h7000, 15'h4011,
                                   15'h004E, 15'h2085, 15'h1A20, 15'h440A, 15'h01C0, 15'h2A12};
        logic [14:0] val  [12] = '{15'h0005, 15'h0018, 15'h0040, 15'h0F00, 15'h4000, 15'h4001,
                                   15'h000E, 15'h2080, 15'h1220, 15'h0402, 15'h01C0, 15'h2800};
        logic [63:0] m;
        logic [14:0] o;
        int lat;
        for (int i = 0; i < 12; i++) write_cube(i, care[i], val[i]);
        write_edge(0, 0, 12);
        for (int e = 1; e < N_EDGES; e++) write_edge(e, 0, 0);
        for (int i = 0; i < 300; i++) begin
            o = 15'(i * 2731 + 17);
            if (i == 0) o = 15'h0000;
            if (i == 1) o = 15'h7FFF;
            run_query(o, m, lat);
            vectors++; if (m[0] !== golden(o)) begin miscompares++; $display("FAIL sop_edge0 occ=%h: got %b want %b", o, m[0], golden(o)); end
            vectors++; if (m[63:1] !== 63'h0) begin miscompares++; $display("FAIL sop_empty_edges occ=%h: got %h want 0", o, m[63:1]); end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [63:0] m;
        int lat;
        int cnt;
        write_cube(20, 15'h0000, 15'h0000);           // always matches
        for (int e = 0; e < 5; e++) write_edge(e, 20, 1);
        write_edge(5, 0, 12);                          // SOP table, occ=0 misses all 12
        @(negedge CLK);
        occ      = 15'h0000;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        cnt = 1;
        while (cnt < 15) begin @(negedge CLK); cnt++; end
        vectors++; if (edge_mask !== 64'h1F) begin miscompares++; $display("FAIL midscan_progress: got %h want 1f", edge_mask); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midscan_busy: got %b want 1", busy); end
        RST = 1'b1;
        @(negedge CLK);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midscan_rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (edge_mask !== 64'h0) begin miscompares++; $display("FAIL midscan_rst_mask: got %h want 0", edge_mask); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midscan_rst_in_ready: got %b want 1", in_ready); end
        RST = 1'b0;
        run_query(15'h0000, m, lat);
        vectors++; if (m !== 64'h1F) begin miscompares++; $display("FAIL midscan_rerun_mask: got %h want 1f", m); end
        vectors++; if (lat !== 81) begin miscompares++; $display("FAIL midscan_rerun_latency: got %0d want 81", lat); end
    endtask

    task automatic test_early_exit();
        logic [63:0] m;
        int lat;
        for (int e = 1; e < 6; e++) write_edge(e, 0, 0);
        write_edge(0, 20, 8);                          // first cube has care = 0
        run_query(15'h5A5A, m, lat);
        vectors++; if (m !== 64'h1) begin miscompares++; $display("FAIL early_exit_mask: got %h want 1", m); end
        vectors++; if (lat !== 65) begin miscompares++; $display("FAIL early_exit_latency: got %0d want 65", lat); end
    endtask

    task automatic test_wrap();
        logic [63:0] m;
        int lat;
        write_edge(0, 0, 0);
        write_cube(510, 15'h7FFF, 15'h7FFF);
        write_cube(511, 15'h7FFF, 15'h7FFF);
        write_cube(0,   15'h7FFF, 15'h7FFF);
        write_cube(1,   15'h7FFF, 15'h1234);
        write_edge(3, 510, 4);
        run_query(15'h1234, m, lat);
        vectors++; if (m !== 64'h8) begin miscompares++; $display("FAIL wrap_hit_mask: got %h want 8", m); end
        vectors++; if (lat !== 68) begin miscompares++; $display("FAIL wrap_hit_latency: got %0d want 68", lat); end
        run_query(15'h0001, m, lat);
        vectors++; if (m !== 64'h0) begin miscompares++; $display("FAIL wrap_miss_mask: got %h want 0", m); end
        vectors++; if (lat !== 68) begin miscompares++; $display("FAIL wrap_miss_latency: got %0d want 68", lat); end
        run_query(15'h7FFF, m, lat);
        vectors++; if (m !== 64'h8) begin miscompares++; $display("FAIL wrap_first_mask: got %h want 8", m); end
        vectors++; if (lat !== 65) begin miscompares++; $display("FAIL wrap_first_latency: got %0d want 65", lat); end
    endtask

    task automatic test_backpressure();
        int cnt;
        @(negedge CLK);
        occ      = 15'h1234;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 3000) begin @(negedge CLK); cnt++; end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_result_timeout: out_valid %b want 1", out_valid); end
        occ      = 15'h0001;                           // would give a different mask
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid cyc%0d: got %b want 1", i, out_valid); end
            vectors++; if (edge_mask !== 64'h8) begin miscompares++; $display("FAIL bp_mask cyc%0d: got %h want 8", i, edge_mask); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_after_busy: got %b want 0", busy); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_after_out_valid: got %b want 0", out_valid); end
        vectors++; if (edge_mask !== 64'h8) begin miscompares++; $display("FAIL bp_mask_hold: got %h want 8", edge_mask); end
    endtask

    task automatic test_cfg();
        logic [63:0] m;
        int lat;
        int cnt;
        // Write attempted during the scan of edge 3 must be dropped.
        @(negedge CLK);
        occ      = 15'h1234;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        cnt = 1;
        while (cnt < 6) begin @(negedge CLK); cnt++; end
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg_err_before: got %b want 0", cfg_err); end
        cfg_we    = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = TAW'(1);
        cfg_wdata = {15'h7FFF, 15'h0000};
        @(negedge CLK); cnt++;
        cfg_we = 1'b0;
        vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
        @(negedge CLK); cnt++;
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg_err_one_cycle: got %b want 0", cfg_err); end
        finish_query(cnt, m, lat);
        vectors++; if (m !== 64'h8) begin miscompares++; $display("FAIL cfg_busy_write_mask: got %h want 8", m); end
        vectors++; if (lat !== 68) begin miscompares++; $display("FAIL cfg_busy_write_latency: got %0d want 68", lat); end
        // Write in the accept cycle is used by that query.
        @(negedge CLK);
        occ       = 15'h0ABC;
        in_valid  = 1'b1;
        cfg_we    = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = TAW'(1);
        cfg_wdata = {15'h7FFF, 15'h0ABC};
        @(negedge CLK);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg_idle_no_err: got %b want 0", cfg_err); end
        finish_query(1, m, lat);
        vectors++; if (m !== 64'h8) begin miscompares++; $display("FAIL cfg_same_cycle_mask: got %h want 8", m); end
        vectors++; if (lat !== 68) begin miscompares++; $display("FAIL cfg_same_cycle_latency: got %0d want 68", lat); end
    endtask

    initial begin
        test_reset();
        test_sop();
        test_reset_mid_scan();
        test_early_exit();
        test_wrap();
        test_backpressure();
        test_cfg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
